scratchpad_access_arbiter: RTL and testbench
============================================

Name: scratchpad_access_arbiter

Overview:
- Shares the single-port synchronous scratchpad SRAM between two requesters: the core datapath (LSW/SSW ops) and the host MMIO path.
- Sits between the core's scratchpad op decode and the SRAM macro, replacing direct core/host SRAM wiring.
- Generates the core's multi-cycle stall and a conflict pulse for the performance counters.
- Fixed core priority, with a starvation guard that guarantees host progress.

Parameters:
- WORD_WIDTH, 32, data width in bits (TIA_WORD_WIDTH).
- DEPTH, 256, scratchpad words; must be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), word address width (derived).
- HOST_STARVE_LIMIT, 4, consecutive denied host-pending cycles before the host is forced a grant; legal range 1..15.

Ports:
- clock  in  1  positive-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  active-high; when low, no new grants are issued.
- core_req_valid  in  1  core request; held stable until completion.
- core_req_write  in  1  1 = SSW (store), 0 = LSW (load).
- core_req_addr  in  ADDR_WIDTH  core word address.
- core_req_wdata  in  WORD_WIDTH  core store data.
- core_resp_valid  out  1  core load data valid (one-cycle pulse).
- core_resp_rdata  out  WORD_WIDTH  core load data.
- core_stall  out  1  core must hold its instruction this cycle.
- core_conflict  out  1  core request was denied because the host was granted.
- host_req_valid  in  1  host request.
- host_req_write  in  1  1 = write, 0 = read.
- host_req_addr  in  ADDR_WIDTH  host word address.
- host_req_wdata  in  WORD_WIDTH  host write data.
- host_req_ready  out  1  host request accepted this cycle.
- host_resp_valid  out  1  host read data valid (one-cycle pulse).
- host_resp_rdata  out  WORD_WIDTH  host read data.
- sram_en  out  1  SRAM access strobe.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_wdata  out  WORD_WIDTH  SRAM write data.
- sram_rdata  in  WORD_WIDTH  SRAM read data; valid one cycle after a read strobe.

Behaviour:
- Reset (reset==0 at the clock edge):
  - inflight=NONE, starve_count=0.
  - All registered outputs are 0.
  - Any in-flight read is discarded; no resp_valid pulse follows reset.
- State: the inflight register, one of {NONE, CORE, HOST}. It records the owner of the read issued in the previous cycle, and is the only sequencing state.
- Eligibility:
  - core_elig = core_req_valid && inflight!=CORE. A completing core read is never re-issued.
  - host_elig = host_req_valid.
- Grant decision (combinational, only when enable=1):
  - If host_elig && (!core_elig || starve_count==HOST_STARVE_LIMIT): grant HOST.
  - Else if core_elig: grant CORE.
  - Else: grant nothing.
- SRAM drive:
  - sram_en = grant != NONE.
  - sram_we, sram_addr and sram_wdata are taken from the granted requester.
  - All SRAM outputs are 0 when nothing is granted.
- host_req_ready = (grant==HOST). Host writes complete in the grant cycle.
- Next inflight:
  - CORE if the granted core access is a read.
  - HOST if the granted host access is a read.
  - NONE otherwise, including whenever enable=0.
- Read return (exactly one cycle after grant):
  - core_resp_valid = (inflight==CORE); core_resp_rdata = sram_rdata, else 0.
  - host_resp_valid and host_resp_rdata follow the same rule for inflight==HOST.
  - The return occurs even if enable has dropped.
- core_stall = core_req_valid && !(grant==CORE && core_req_write) && !(inflight==CORE).
  - Uncontended SSW: 0 stall cycles.
  - Uncontended LSW: exactly 1 stall cycle.
- core_conflict = core_elig && grant==HOST.
- starve_count:
  - Clears on a host grant.
  - Increments (saturating at HOST_STARVE_LIMIT) when host_req_valid && enable && grant!=HOST.
  - Holds otherwise.
- Back-to-back: a new grant may issue in the same cycle a read returns, so sustained throughput is one access per cycle.
- Same-address write then read by different owners: the read observes the written value, because the SRAM is single-port and the accesses are serialized.
- Address width equals log2(DEPTH), so there is no out-of-range case.

Decomposition:
- Shared core package:
  - enum owner_t {OWNER_NONE, OWNER_CORE, OWNER_HOST}.
  - Constant TIA_SCRATCHPAD_DEPTH.
  - Constant TIA_SCRATCHPAD_ADDR_WIDTH.
- One sub-module: scratchpad_starvation_counter. It holds the saturating starve_count and exports a limit-reached flag.
- The grant mux stays in the top module.

Test Plan:
- Core LSW addr 0x10 with SRAM preloaded 0xDEADBEEF, host idle -> stall=1 in cycle N; sram_en=1, we=0, addr=0x10 in N; core_resp_valid=1 with 0xDEADBEEF in N+1, stall=0.
- Core SSW addr 0x05 data 0x1234 and host read addr 0x05 in the same cycle -> core granted (no stall); host_req_ready=1 next cycle; host_resp_rdata=0x1234 one cycle later; core_conflict stays 0.
- Continuous core SSWs with host read pending, HOST_STARVE_LIMIT=4 -> 4 core grants, then host_req_ready=1 on the 5th cycle; core_stall=1 and core_conflict=1 in that cycle; starve_count returns to 0.
- Core LSW followed by host read on consecutive cycles -> sram_en high on both cycles; core_resp_valid then host_resp_valid on successive cycles with no bubble.
- Host read granted, reset=0 on the next edge -> host_resp_valid stays 0; all outputs 0; inflight=NONE.
- enable=0 with both requesters valid -> sram_en=0, host_req_ready=0, core_stall=1; a read granted the cycle before enable fell still returns resp_valid=1.

Source files
------------

// File: rtl/scratchpad_access_arbiter_pkg.sv
// Shared scratchpad definitions: access owner encoding and scratchpad geometry.
package scratchpad_access_arbiter_pkg;

    localparam int TIA_SCRATCHPAD_DEPTH      = 256;
    localparam int TIA_SCRATCHPAD_ADDR_WIDTH = $clog2(TIA_SCRATCHPAD_DEPTH);

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CORE = 2'd1,
        OWNER_HOST = 2'd2
    } owner_t;

endpackage

// File: rtl/scratchpad_access_arbiter_starvation_counter.sv
// Counts consecutive cycles a pending host request was denied; flags when the
// host must be forced a grant.
module scratchpad_starvation_counter
    import scratchpad_access_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic limit_reached
);

    localparam logic [3:0] LIMIT_C = 4'(LIMIT);

    logic [3:0] starve_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_count <= '0;
        end else if (clear) begin
            starve_count <= '0;
        end else if (incr && (starve_count != LIMIT_C)) begin
            starve_count <= starve_count + 4'd1;
        end
    end

    assign limit_reached = (starve_count == LIMIT_C);

endmodule

// File: rtl/scratchpad_access_arbiter.sv
// Arbitrates the single-port scratchpad SRAM between core LSW/SSW ops and host
// MMIO, core first, with a starvation guard that forces host progress.
module scratchpad_access_arbiter
    import scratchpad_access_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH        = 32,
    parameter int DEPTH             = TIA_SCRATCHPAD_DEPTH,
    parameter int ADDR_WIDTH        = $clog2(DEPTH),
    parameter int HOST_STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,

    input  logic                  core_req_valid,
    input  logic                  core_req_write,
    input  logic [ADDR_WIDTH-1:0] core_req_addr,
    input  logic [WORD_WIDTH-1:0] core_req_wdata,
    output logic                  core_resp_valid,
    output logic [WORD_WIDTH-1:0] core_resp_rdata,
    output logic                  core_stall,
    output logic                  core_conflict,

    input  logic                  host_req_valid,
    input  logic                  host_req_write,
    input  logic [ADDR_WIDTH-1:0] host_req_addr,
    input  logic [WORD_WIDTH-1:0] host_req_wdata,
    output logic                  host_req_ready,
    output logic                  host_resp_valid,
    output logic [WORD_WIDTH-1:0] host_resp_rdata,

    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [WORD_WIDTH-1:0] sram_wdata,
    input  logic [WORD_WIDTH-1:0] sram_rdata
);

    owner_t inflight;
    owner_t inflight_next;
    owner_t grant;
    logic   core_elig;
    logic   starve_limit;
    logic   starve_incr;
    logic   starve_clear;

    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight <= OWNER_NONE;
        end else begin
            inflight <= inflight_next;
        end
    end

    // Stage p0: grant decision and SRAM drive in the request cycle.
    always_comb begin
        core_elig = core_req_valid && (inflight != OWNER_CORE);
        grant     = OWNER_NONE;
        if (enable && reset) begin
            if (host_req_valid && (!core_elig || starve_limit)) begin
                grant = OWNER_HOST;
            end else if (core_elig) begin
                grant = OWNER_CORE;
            end
        end
    end

    always_comb begin
        sram_en       = 1'b0;
        sram_we       = 1'b0;
        sram_addr     = '0;
        sram_wdata    = '0;
        inflight_next = OWNER_NONE;
        case (grant)
            OWNER_CORE: begin
                sram_en    = 1'b1;
                sram_we    = core_req_write;
                sram_addr  = core_req_addr;
                sram_wdata = core_req_wdata;
                if (!core_req_write) begin
                    inflight_next = OWNER_CORE;
                end
            end
            OWNER_HOST: begin
                sram_en    = 1'b1;
                sram_we    = host_req_write;
                sram_addr  = host_req_addr;
                sram_wdata = host_req_wdata;
                if (!host_req_write) begin
                    inflight_next = OWNER_HOST;
                end
            end
            default: begin
                sram_en = 1'b0;
            end
        endcase
    end

    assign host_req_ready = (grant == OWNER_HOST);
    assign core_conflict  = core_elig && (grant == OWNER_HOST);
    // A returning core read releases the stall even though nothing is granted.
    assign core_stall     = core_req_valid
                          && !((grant == OWNER_CORE) && core_req_write)
                          && (inflight != OWNER_CORE);

    // Stage p1: read data returns one cycle after the grant; reset discards it.
    assign core_resp_valid = reset && (inflight == OWNER_CORE);
    assign core_resp_rdata = core_resp_valid ? sram_rdata : '0;
    assign host_resp_valid = reset && (inflight == OWNER_HOST);
    assign host_resp_rdata = host_resp_valid ? sram_rdata : '0;

    assign starve_clear = (grant == OWNER_HOST);
    assign starve_incr  = host_req_valid && enable && (grant != OWNER_HOST);

    scratchpad_starvation_counter #(
        .LIMIT (HOST_STARVE_LIMIT)
    ) u_starve (
        .clock         (clock),
        .reset         (reset),
        .clear         (starve_clear),
        .incr          (starve_incr),
        .limit_reached (starve_limit)
    );

endmodule

// File: tb/tb_scratchpad_access_arbiter.sv
// Bench for scratchpad_access_arbiter: directed scenarios plus random traffic
// checked against a behavioural arbitration/memory model.
module tb_scratchpad_access_arbiter;

    localparam int WW    = 32;
    localparam int AW    = 8;
    localparam int LIMIT = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          core_req_valid;
    logic          core_req_write;
    logic [AW-1:0] core_req_addr;
    logic [WW-1:0] core_req_wdata;
    logic          core_resp_valid;
    logic [WW-1:0] core_resp_rdata;
    logic          core_stall;
    logic          core_conflict;
    logic          host_req_valid;
    logic          host_req_write;
    logic [AW-1:0] host_req_addr;
    logic [WW-1:0] host_req_wdata;
    logic          host_req_ready;
    logic          host_resp_valid;
    logic [WW-1:0] host_resp_rdata;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [WW-1:0] sram_wdata;
    logic [WW-1:0] sram_rdata;

    always #5 clock = ~clock;

    scratchpad_access_arbiter #(
        .WORD_WIDTH        (WW),
        .DEPTH             (256),
        .HOST_STARVE_LIMIT (LIMIT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .core_req_valid  (core_req_valid),
        .core_req_write  (core_req_write),
        .core_req_addr   (core_req_addr),
        .core_req_wdata  (core_req_wdata),
        .core_resp_valid (core_resp_valid),
        .core_resp_rdata (core_resp_rdata),
        .core_stall      (core_stall),
        .core_conflict   (core_conflict),
        .host_req_valid  (host_req_valid),
        .host_req_write  (host_req_write),
        .host_req_addr   (host_req_addr),
        .host_req_wdata  (host_req_wdata),
        .host_req_ready  (host_req_ready),
        .host_resp_valid (host_resp_valid),
        .host_resp_rdata (host_resp_rdata),
        .sram_en         (sram_en),
        .sram_we         (sram_we),
        .sram_addr       (sram_addr),
        .sram_wdata      (sram_wdata),
        .sram_rdata      (sram_rdata)
    );

    // Single-port synchronous SRAM macro stand-in.
    logic [WW-1:0] sram_mem [0:255];
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram_mem[sram_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the read returning now (0 none, 1 core, 2 host),
    // the value that read must return, the starvation count and a memory image.
    int            m_pend   = 0;
    logic [WW-1:0] m_rdata  = '0;
    int            m_starve = 0;
    logic [WW-1:0] ref_mem [0:255];
    int            m_grant;
    logic          m_core_elig;
    logic          core_done;

    logic          e_sram_en, e_sram_we, e_ready, e_stall, e_conflict;
    logic          e_core_rv, e_host_rv;
    logic [AW-1:0] e_sram_addr;
    logic [WW-1:0] e_sram_wdata, e_core_rd, e_host_rd;

    function automatic void model_eval();
        m_core_elig = core_req_valid && (m_pend != 1);
        m_grant = 0;
        if (enable && reset) begin
            if (host_req_valid && (!m_core_elig || m_starve == LIMIT)) m_grant = 2;
            else if (m_core_elig) m_grant = 1;
        end
        e_sram_en    = (m_grant != 0);
        e_sram_we    = (m_grant == 1) ? core_req_write : (m_grant == 2) ? host_req_write : 1'b0;
        e_sram_addr  = (m_grant == 1) ? core_req_addr  : (m_grant == 2) ? host_req_addr  : '0;
        e_sram_wdata = (m_grant == 1) ? core_req_wdata : (m_grant == 2) ? host_req_wdata : '0;
        e_ready      = (m_grant == 2);
        e_conflict   = m_core_elig && (m_grant == 2);
        e_stall      = core_req_valid && !(m_grant == 1 && core_req_write) && (m_pend != 1);
        e_core_rv    = reset && (m_pend == 1);
        e_host_rv    = reset && (m_pend == 2);
        e_core_rd    = e_core_rv ? m_rdata : '0;
        e_host_rd    = e_host_rv ? m_rdata : '0;
        core_done    = core_req_valid && !e_stall;
    endfunction

    function automatic void model_update();
        if (!reset) begin
            m_pend   = 0;
            m_starve = 0;
        end else begin
            m_pend = 0;
            if (m_grant == 1) begin
                if (core_req_write) ref_mem[core_req_addr] = core_req_wdata;
                else begin m_pend = 1; m_rdata = ref_mem[core_req_addr]; end
            end else if (m_grant == 2) begin
                if (host_req_write) ref_mem[host_req_addr] = host_req_wdata;
                else begin m_pend = 2; m_rdata = ref_mem[host_req_addr]; end
            end
            if (m_grant == 2) m_starve = 0;
            else if (host_req_valid && enable && m_starve < LIMIT) m_starve++;
        end
    endfunction

    // Called just after a falling edge with inputs set; checks, then advances a cycle.
    task automatic step();
        #1;
        model_eval();
        check_val("sram_en",    32'(sram_en),         32'(e_sram_en));
        check_val("sram_we",    32'(sram_we),         32'(e_sram_we));
        check_val("sram_addr",  32'(sram_addr),       32'(e_sram_addr));
        check_val("sram_wdata", sram_wdata,           e_sram_wdata);
        check_val("host_ready", 32'(host_req_ready),  32'(e_ready));
        check_val("conflict",   32'(core_conflict),   32'(e_conflict));
        check_val("stall",      32'(core_stall),      32'(e_stall));
        check_val("core_rv",    32'(core_resp_valid), 32'(e_core_rv));
        check_val("core_rd",    core_resp_rdata,      e_core_rd);
        check_val("host_rv",    32'(host_resp_valid), 32'(e_host_rv));
        check_val("host_rd",    host_resp_rdata,      e_host_rd);
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        core_req_valid = 1'b0; core_req_write = 1'b0; core_req_addr = '0; core_req_wdata = '0;
        host_req_valid = 1'b0; host_req_write = 1'b0; host_req_addr = '0; host_req_wdata = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        idle_inputs();
        @(negedge clock);
        #1;
        check_val("rst_sram_en", 32'(sram_en), 32'd0);
        check_val("rst_core_rv", 32'(core_resp_valid), 32'd0);
        check_val("rst_host_rv", 32'(host_resp_valid), 32'd0);
        step();
        reset = 1'b1;

        // Preload words 0..31 with A5000000|addr through the host port.
        for (int a = 0; a < 32; a++) begin
            host_req_valid = 1'b1; host_req_write = 1'b1;
            host_req_addr = AW'(a); host_req_wdata = 32'hA500_0000 | 32'(a);
            step();
        end
        host_req_addr = 8'h10; host_req_wdata = 32'hDEAD_BEEF;
        step();
        idle_inputs();

        // Uncontended LSW: one stall cycle, data next cycle.
        core_req_valid = 1'b1; core_req_write = 1'b0; core_req_addr = 8'h10;
        #1;
        check_val("lsw_stall", 32'(core_stall), 32'd1);
        check_val("lsw_en",    32'(sram_en),    32'd1);
        check_val("lsw_addr",  32'(sram_addr),  32'h10);
        step();
        #1;
        check_val("lsw_rv",    32'(core_resp_valid), 32'd1);
        check_val("lsw_rd",    core_resp_rdata,      32'hDEAD_BEEF);
        check_val("lsw_stall_done", 32'(core_stall), 32'd0);
        step();
        idle_inputs();

        // SSW and host read to the same word: core first, host sees the store.
        core_req_valid = 1'b1; core_req_write = 1'b1; core_req_addr = 8'h05; core_req_wdata = 32'h1234;
        host_req_valid = 1'b1; host_req_write = 1'b0; host_req_addr = 8'h05;
        #1;
        check_val("ssw_stall", 32'(core_stall), 32'd0);
        check_val("ssw_host_wait", 32'(host_req_ready), 32'd0);
        step();
        core_req_valid = 1'b0;
        #1;
        check_val("ssw_host_ready", 32'(host_req_ready), 32'd1);
        check_val("ssw_conflict", 32'(core_conflict), 32'd0);
        step();
        host_req_valid = 1'b0;
        #1;
        check_val("ssw_host_rd", host_resp_rdata, 32'h1234);
        step();

        // Starvation guard: four core SSWs win, the fifth cycle goes to the host.
        host_req_valid = 1'b1; host_req_write = 1'b0; host_req_addr = 8'h03;
        for (int k = 0; k < LIMIT; k++) begin
            core_req_valid = 1'b1; core_req_write = 1'b1; core_req_addr = AW'(k + 20);
            core_req_wdata = $urandom;
            #1;
            check_val("starve_wait", 32'(host_req_ready), 32'd0);
            step();
        end
        core_req_addr = 8'h18; core_req_wdata = 32'h5555_0018;
        #1;
        check_val("starve_ready",    32'(host_req_ready), 32'd1);
        check_val("starve_stall",    32'(core_stall),     32'd1);
        check_val("starve_conflict", 32'(core_conflict),  32'd1);
        step();
        host_req_valid = 1'b0;
        step();
        idle_inputs();

        // Core LSW then host read back to back: no bubble.
        core_req_valid = 1'b1; core_req_write = 1'b0; core_req_addr = 8'h07;
        step();
        host_req_valid = 1'b1; host_req_write = 1'b0; host_req_addr = 8'h09;
        #1;
        check_val("b2b_en",    32'(sram_en),         32'd1);
        check_val("b2b_core_rv", 32'(core_resp_valid), 32'd1);
        check_val("b2b_core_rd", core_resp_rdata, 32'hA500_0007);
        step();
        idle_inputs();
        #1;
        check_val("b2b_host_rv", 32'(host_resp_valid), 32'd1);
        check_val("b2b_host_rd", host_resp_rdata, 32'hA500_0009);
        step();

        // Host read granted, then reset: the return is discarded.
        host_req_valid = 1'b1; host_req_write = 1'b0; host_req_addr = 8'h02;
        step();
        idle_inputs();
        reset = 1'b0;
        #1;
        check_val("rst_drop_rv", 32'(host_resp_valid), 32'd0);
        step();
        reset = 1'b1;
        #1;
        check_val("rst_after_rv", 32'(host_resp_valid), 32'd0);
        check_val("rst_after_en", 32'(sram_en), 32'd0);
        step();

        // enable low: no grants, but the read granted before still returns.
        host_req_valid = 1'b1; host_req_write = 1'b0; host_req_addr = 8'h04;
        step();
        enable = 1'b0;
        core_req_valid = 1'b1; core_req_write = 1'b0; core_req_addr = 8'h01;
        #1;
        check_val("dis_en",      32'(sram_en),         32'd0);
        check_val("dis_ready",   32'(host_req_ready),  32'd0);
        check_val("dis_stall",   32'(core_stall),      32'd1);
        check_val("dis_host_rv", 32'(host_resp_valid), 32'd1);
        check_val("dis_host_rd", host_resp_rdata,      32'hA500_0004);
        step();
        enable = 1'b1;

        // Random traffic; the core holds each request until it completes.
        for (int i = 0; i < 1500; i++) begin
            if (!core_req_valid || core_done) begin
                core_req_valid = ($urandom_range(0, 9) < 6);
                core_req_write = 1'($urandom_range(0, 1));
                core_req_addr  = AW'($urandom_range(0, 31));
                core_req_wdata = $urandom;
            end
            host_req_valid = ($urandom_range(0, 9) < 5);
            host_req_write = 1'($urandom_range(0, 1));
            host_req_addr  = AW'($urandom_range(0, 31));
            host_req_wdata = $urandom;
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
